// File: rtl/seq_code_packer.sv
// seq_code_packer: packs a stream of 3-bit nucleotide codes (A=000, C=001, G=010, T=011, N=100)
// LSB-first into CODES_PER_WORD-slot words for the GACT sequence buffer. Each sequence ends
// with a flushed partial word, padded with N. The block also reports the sequence length.
//
// Optional feature: define SEQ_PACKER_NCOUNT_EN to add the n_count output, which counts the
// N codes accepted in the current sequence. Padding slots are not counted.
//
// Ports:
//   clk, rst_n           rising-edge clock, synchronous active-low reset
//   in_valid/in_ready    code handshake; in_code is the code, in_last marks the sequence end
//   out_valid/out_ready  word handshake; out_word holds the packed codes (slot k at k*CODE_W)
//   out_count            number of real codes in out_word (1..CODES_PER_WORD)
//   out_last             out_word holds the final code of its sequence
//   seq_len              codes accepted in the current or last sequence (saturating)
//   seq_done             one-cycle pulse when a word with out_last=1 is accepted
//   n_count              (SEQ_PACKER_NCOUNT_EN only) N codes in the current sequence

module seq_code_packer #(
    parameter int unsigned CODES_PER_WORD = 10,
    parameter int unsigned CODE_W         = 3,
    parameter int unsigned LEN_W          = 16,
    localparam int unsigned WORD_W        = CODES_PER_WORD * CODE_W,
    localparam int unsigned CNT_W         = $clog2(CODES_PER_WORD + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CODE_W-1:0] in_code,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_word,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_last,
    output logic [LEN_W-1:0]  seq_len,
`ifdef SEQ_PACKER_NCOUNT_EN
    output logic [LEN_W-1:0]  n_count,
`endif
    output logic              seq_done
);

    localparam int unsigned IDX_W = $clog2(CODES_PER_WORD);

    localparam logic [CODE_W-1:0] CodeN   = CODE_W'(4);
    localparam logic [WORD_W-1:0] PadWord = {CODES_PER_WORD{CodeN}};

    // HOLD means a packed word is registered and has not yet been taken by the sink.
    localparam logic [0:0] StAccum = 1'b0;
    localparam logic [0:0] StHold  = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [WORD_W-1:0] acc_q, acc_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              last_q, last_d;
    logic [LEN_W-1:0]  seq_len_q, seq_len_d;
    logic              seq_end_q, seq_end_d;
    logic              seq_done_q, seq_done_d;

    logic              in_fire;
    logic              out_fire;
    logic              word_done;
    logic              seq_clear;
    logic [WORD_W-1:0] acc_fill;

    assign out_valid = (state_q == StHold);
    assign in_ready  = !out_valid || out_ready;
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;
    assign word_done = in_last || (idx_q == IDX_W'(CODES_PER_WORD - 1));

    // The first code after the final word is accepted restarts the sequence counters. That
    // includes a code accepted in the same cycle as that word.
    assign seq_clear = seq_end_q || (out_fire && last_q);

    assign out_word  = word_q;
    assign out_count = count_q;
    assign out_last  = last_q;
    assign seq_len   = seq_len_q;
    assign seq_done  = seq_done_q;

    always_comb begin
        acc_fill = acc_q;
        acc_fill[32'(idx_q) * CODE_W +: CODE_W] = in_code;
    end

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        idx_d      = idx_q;
        word_d     = word_q;
        count_d    = count_q;
        last_d     = last_q;
        seq_len_d  = seq_len_q;
        seq_end_d  = seq_end_q;
        seq_done_d = out_fire && last_q;

        if (out_fire) begin
            state_d = StAccum;
            if (last_q) begin
                seq_end_d = 1'b1;
            end
        end

        if (in_fire) begin
            seq_end_d = 1'b0;
            if (seq_clear) begin
                seq_len_d = LEN_W'(1);
            end else if (seq_len_q != '1) begin
                seq_len_d = seq_len_q + LEN_W'(1);
            end

            if (word_done) begin
                // A completing word overrides the drain, so the output never bubbles.
                word_d  = acc_fill;
                count_d = CNT_W'(idx_q) + CNT_W'(1);
                last_d  = in_last;
                state_d = StHold;
                acc_d   = PadWord;
                idx_d   = '0;
            end else begin
                acc_d = acc_fill;
                idx_d = idx_q + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StAccum;
            acc_q      <= PadWord;
            idx_q      <= '0;
            word_q     <= '0;
            count_q    <= '0;
            last_q     <= 1'b0;
            seq_len_q  <= '0;
            seq_end_q  <= 1'b0;
            seq_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            idx_q      <= idx_d;
            word_q     <= word_d;
            count_q    <= count_d;
            last_q     <= last_d;
            seq_len_q  <= seq_len_d;
            seq_end_q  <= seq_end_d;
            seq_done_q <= seq_done_d;
        end
    end

`ifdef SEQ_PACKER_NCOUNT_EN
    logic [LEN_W-1:0] n_count_q, n_count_d;
    logic             code_is_n;

    assign code_is_n = (in_code == CodeN);
    assign n_count   = n_count_q;

    always_comb begin
        n_count_d = n_count_q;
        if (in_fire) begin
            if (seq_clear) begin
                n_count_d = LEN_W'(code_is_n);
            end else if (code_is_n && (n_count_q != '1)) begin
                n_count_d = n_count_q + LEN_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            n_count_q <= '0;
        end else begin
            n_count_q <= n_count_d;
        end
    end
`else
    // No N counter in this build.
`endif

endmodule

// File: tb/tb_seq_code_packer.sv
// Directed self-checking bench for seq_code_packer. It has a default instance and a LEN_W=4
// instance that share the same stimulus. The second instance exercises seq_len saturation.

module tb_seq_code_packer;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_code;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [29:0] out_word;
    logic [3:0]  out_count;
    logic        out_last;
    logic [15:0] seq_len;
    logic        seq_done;

    logic        in_ready_s;
    logic        out_valid_s;
    logic [29:0] out_word_s;
    logic [3:0]  out_count_s;
    logic        out_last_s;
    logic [3:0]  seq_len_s;
    logic        seq_done_s;

`ifdef SEQ_PACKER_NCOUNT_EN
    logic [15:0] n_count;
    logic [3:0]  n_count_s;
`endif

    int n_pass  = 0;
    int n_total = 0;

    seq_code_packer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_code   (in_code),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_word  (out_word),
        .out_count (out_count),
        .out_last  (out_last),
        .seq_len   (seq_len),
`ifdef SEQ_PACKER_NCOUNT_EN
        .n_count   (n_count),
`endif
        .seq_done  (seq_done)
    );

    seq_code_packer #(
        .LEN_W(4)
    ) dut_s (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready_s),
        .in_code   (in_code),
        .in_last   (in_last),
        .out_valid (out_valid_s),
        .out_ready (out_ready),
        .out_word  (out_word_s),
        .out_count (out_count_s),
        .out_last  (out_last_s),
        .seq_len   (seq_len_s),
`ifdef SEQ_PACKER_NCOUNT_EN
        .n_count   (n_count_s),
`endif
        .seq_done  (seq_done_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] code, input logic last);
        in_valid = 1'b1;
        in_code  = code;
        in_last  = last;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_code   = 3'd0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_word", 64'(out_word), 64'd0);
        chk("rst_out_count", 64'(out_count), 64'd0);
        chk("rst_out_last", 64'(out_last), 64'd0);
        chk("rst_seq_len", 64'(seq_len), 64'd0);
        chk("rst_seq_done", 64'(seq_done), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        rst_n = 1'b1;

        // ACGTNACGTN, last on the tenth code
        for (int i = 0; i < 10; i++) send(3'(i % 5), i == 9);
        chk("t1_valid", 64'(out_valid), 64'd1);
        chk("t1_word", 64'(out_word), 64'(30'o4321043210));
        chk("t1_count", 64'(out_count), 64'd10);
        chk("t1_last", 64'(out_last), 64'd1);
        chk("t1_seq_len", 64'(seq_len), 64'd10);
        chk("t1_done_early", 64'(seq_done), 64'd0);
        tick();
        chk("t1_done", 64'(seq_done), 64'd1);
        chk("t1_drained", 64'(out_valid), 64'd0);
        tick();
        chk("t1_done_pulse", 64'(seq_done), 64'd0);

        // 13 x T: one full word, then a 3-code flush
        for (int i = 0; i < 13; i++) begin
            send(3'd3, i == 12);
            if (i == 9) begin
                chk("t2_w1_word", 64'(out_word), 64'(30'o3333333333));
                chk("t2_w1_count", 64'(out_count), 64'd10);
                chk("t2_w1_last", 64'(out_last), 64'd0);
            end
        end
        chk("t2_w2_word", 64'(out_word), 64'(30'o4444444333));
        chk("t2_w2_count", 64'(out_count), 64'd3);
        chk("t2_w2_last", 64'(out_last), 64'd1);
        chk("t2_seq_len", 64'(seq_len), 64'd13);
        tick();
        chk("t2_done", 64'(seq_done), 64'd1);

        // Single G
        send(3'd2, 1'b1);
        chk("t3_valid", 64'(out_valid), 64'd1);
        chk("t3_word", 64'(out_word), 64'(30'o4444444442));
        chk("t3_count", 64'(out_count), 64'd1);
        chk("t3_seq_len", 64'(seq_len), 64'd1);
        tick();
        chk("t3_done", 64'(seq_done), 64'd1);

        // Back-pressure: hold the word for 5 cycles while the next code waits
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) send(3'd1, 1'b0);
        chk("t4_word", 64'(out_word), 64'(30'o1111111111));
        in_valid = 1'b1;
        in_code  = 3'd0;
        in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t4_stall_ready", 64'(in_ready), 64'd0);
            chk("t4_stall_word", 64'(out_word), 64'(30'o1111111111));
            chk("t4_stall_valid", 64'(out_valid), 64'd1);
        end
        chk("t4_stall_len", 64'(seq_len), 64'd10);
        out_ready = 1'b1;
        #1;
        chk("t4_release_ready", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk("t4_next_valid", 64'(out_valid), 64'd1);
        chk("t4_next_word", 64'(out_word), 64'(30'o4444444440));
        chk("t4_next_count", 64'(out_count), 64'd1);
        chk("t4_next_last", 64'(out_last), 64'd1);
        chk("t4_no_done", 64'(seq_done), 64'd0);
        chk("t4_seq_len", 64'(seq_len), 64'd11);
        tick();
        chk("t4_done", 64'(seq_done), 64'd1);

        // Reset with a partial word in the accumulator
        for (int i = 0; i < 4; i++) send(3'd3, 1'b0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("t5_valid", 64'(out_valid), 64'd0);
        chk("t5_word", 64'(out_word), 64'd0);
        chk("t5_count", 64'(out_count), 64'd0);
        chk("t5_seq_len", 64'(seq_len), 64'd0);
        for (int i = 0; i < 10; i++) send(3'd2, i == 9);
        chk("t5_clean_word", 64'(out_word), 64'(30'o2222222222));
        chk("t5_clean_count", 64'(out_count), 64'd10);
        chk("t5_clean_len", 64'(seq_len), 64'd10);
        tick();
        chk("t5_done", 64'(seq_done), 64'd1);

        // 20 codes with N at positions 3, 10 and 17
        for (int i = 0; i < 20; i++) begin
            send((i == 3 || i == 10 || i == 17) ? 3'd4 : 3'd0, i == 19);
            if (i == 9) begin
                chk("t6_w1_word", 64'(out_word), 64'(30'o0000004000));
                chk("t6_w1_last", 64'(out_last), 64'd0);
            end
        end
        chk("t6_w2_word", 64'(out_word), 64'(30'o0040000004));
        chk("t6_w2_count", 64'(out_count), 64'd10);
        chk("t6_w2_last", 64'(out_last), 64'd1);
        chk("t6_seq_len", 64'(seq_len), 64'd20);
        chk("t6_seq_len_sat", 64'(seq_len_s), 64'd15);
`ifdef SEQ_PACKER_NCOUNT_EN
        chk("t6_n_count", 64'(n_count), 64'd3);
        chk("t6_n_count_s", 64'(n_count_s), 64'd3);
`endif
        tick();
        chk("t6_done", 64'(seq_done), 64'd1);
        chk("t6_done_s", 64'(seq_done_s), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
